afifo_wr_arbiter: RTL and testbench

- Write-side arbiter for the async FIFO.
- Shares the single FIFO write port (push/data_in/full) between N_REQ requesters using round-robin, burst-limited grants.
- Sits entirely in the clk_wr domain, directly in front of the FIFO consumer write inputs.
- Guarantees no push while full, and fairness between requesters.

---
 rtl/afifo_pkg.sv | 18 +
 rtl/afifo_rr_pick.sv | 32 +++
 rtl/afifo_wr_arbiter_chk.sv | 21 ++
 rtl/afifo_wr_arbiter.sv | 137 +++++++++++++
 tb/tb_afifo_wr_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/afifo_pkg.sv
// Shared types for the async FIFO write side: data word, arbiter state and
// requester index, plus default arbiter sizing.
package afifo_pkg;

   localparam int WIDTH_DEF     = 8;
   localparam int N_REQ_DEF     = 4;
   localparam int BURST_MAX_DEF = 4;

   typedef logic [WIDTH_DEF-1:0] data_ty;

   typedef logic [$clog2(N_REQ_DEF)-1:0] req_idx_ty;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_ty;

endpackage

// File: rtl/afifo_rr_pick.sv
// Combinational round-robin first-one finder: first set bit of req searching
// upward from rr_ptr with wrap to 0.
module afifo_rr_pick
   import afifo_pkg::*;
#(
   parameter  int N_REQ = N_REQ_DEF,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   logic [IDX_W-1:0] cand_s;
   logic             hit_s;

   // Scan all rotated positions; the first hit wins and later ones are masked
   always_comb begin
      idx    = '0;
      found  = 1'b0;
      cand_s = '0;
      hit_s  = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         cand_s = IDX_W'((int'(rr_ptr) + i) % N_REQ);
         hit_s  = req[cand_s] & ~found;
         idx    = hit_s ? cand_s : idx;
         found  = found | hit_s;
      end
   end

endmodule

// File: rtl/afifo_wr_arbiter_chk.sv
// Protocol invariants for afifo_wr_arbiter: never push into a full FIFO,
// at most one ready, and a push always belongs to the grant holder.
module afifo_wr_arbiter_chk #(
   parameter  int N_REQ = 4,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input logic             clk_wr,
   input logic             wr_rst,
   input logic [N_REQ-1:0] req_ready,
   input logic             push,
   input logic             full,
   input logic [IDX_W-1:0] grant_id
);

   no_push_when_full: assert property (@(posedge clk_wr) disable iff (!wr_rst) !(push && full));

   ready_onehot0: assert property (@(posedge clk_wr) disable iff (!wr_rst) $onehot0(req_ready));

   push_has_ready: assert property (@(posedge clk_wr) disable iff (!wr_rst) push |-> req_ready[grant_id]);

endmodule

// File: rtl/afifo_wr_arbiter.sv
// Write-side arbiter for the async FIFO: round-robin, burst-limited sharing of
// the single push/data_in/full port between N_REQ requesters (clk_wr domain).
module afifo_wr_arbiter
   import afifo_pkg::*;
#(
   parameter  int N_REQ     = N_REQ_DEF,
   parameter  int BURST_MAX = BURST_MAX_DEF,
   parameter  int WIDTH     = $bits(data_ty),
   localparam int IDX_W     = $clog2(N_REQ),
   localparam int BEAT_W    = $clog2(BURST_MAX + 1)
) (
   input  logic                        clk_wr,
   input  logic                        wr_rst,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [N_REQ-1:0][WIDTH-1:0] req_data,
   input  logic [N_REQ-1:0]            req_last,
   output logic [N_REQ-1:0]            req_ready,
   input  logic                        full,
   output logic                        push,
   output logic [WIDTH-1:0]            data_in,
   output logic [IDX_W-1:0]            grant_id,
   output logic                        busy
);

   arb_state_ty       state_r, state_s;
   logic [IDX_W-1:0]  rr_ptr_r, rr_ptr_s;
   logic [IDX_W-1:0]  grant_id_r, grant_id_s;
   logic [BEAT_W-1:0] beat_cnt_r, beat_cnt_s;
   logic [IDX_W-1:0]  pick_idx_s;
   logic              pick_found_s;
   logic              xfer_s;
   logic              cap_hit_s;
   logic              release_s;

   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
      if (int'(i) == N_REQ - 1) begin
         return '0;
      end else begin
         return i + IDX_W'(1);
      end
   endfunction

   afifo_rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req    (req_valid),
      .rr_ptr (rr_ptr_r),
      .idx    (pick_idx_s),
      .found  (pick_found_s)
   );

   // Transfer qualification and grant-release decision for the current holder
   always_comb begin
      xfer_s    = 1'b0;
      cap_hit_s = 1'b0;
      release_s = 1'b0;
      if (state_r == GRANT) begin
         xfer_s    = req_valid[grant_id_r] & ~full;
         cap_hit_s = (beat_cnt_r + BEAT_W'(1)) == BEAT_W'(BURST_MAX);
         // An idle holder only counts as abandoning when the FIFO could take a word
         release_s = (xfer_s & (req_last[grant_id_r] | cap_hit_s)) |
                     (~req_valid[grant_id_r] & ~full);
      end else begin
         xfer_s    = 1'b0;
         cap_hit_s = 1'b0;
         release_s = 1'b0;
      end
   end

   // Next-state, pointer and beat counter
   always_comb begin
      state_s    = state_r;
      rr_ptr_s   = rr_ptr_r;
      grant_id_s = grant_id_r;
      beat_cnt_s = beat_cnt_r;
      case (state_r)
         IDLE: begin
            if (pick_found_s) begin
               state_s    = GRANT;
               grant_id_s = pick_idx_s;
               beat_cnt_s = '0;
            end else begin
               state_s    = IDLE;
            end
         end
         GRANT: begin
            if (xfer_s) begin
               beat_cnt_s = beat_cnt_r + BEAT_W'(1);
            end else begin
               beat_cnt_s = beat_cnt_r;
            end
            if (release_s) begin
               state_s  = IDLE;
               rr_ptr_s = wrap_inc(grant_id_r);
            end else begin
               state_s  = GRANT;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // FIFO-side outputs, only live while a grant is held
   always_comb begin
      req_ready = '0;
      push      = 1'b0;
      data_in   = '0;
      if (state_r == GRANT) begin
         req_ready[grant_id_r] = ~full;
         push                  = xfer_s;
         data_in               = req_data[grant_id_r];
      end else begin
         req_ready = '0;
         push      = 1'b0;
         data_in   = '0;
      end
   end

   assign busy     = (state_r == GRANT);
   assign grant_id = grant_id_r;

   // State, pointer, grant index and beat counter registers
   always_ff @(posedge clk_wr or negedge wr_rst) begin
      if (!wr_rst) begin
         state_r    <= IDLE;
         rr_ptr_r   <= '0;
         grant_id_r <= '0;
         beat_cnt_r <= '0;
      end else begin
         state_r    <= state_s;
         rr_ptr_r   <= rr_ptr_s;
         grant_id_r <= grant_id_s;
         beat_cnt_r <= beat_cnt_s;
      end
   end

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Scoreboard bench for afifo_wr_arbiter: requester queues feed the arbiter,
// expected (id, word) pairs are queued at load time and popped on each push.
module tb_afifo_wr_arbiter;
   import afifo_pkg::*;

   localparam int N  = 4;
   localparam int BM = 4;
   localparam int W  = 8;

   logic                clk_wr = 1'b0;
   logic                wr_rst;
   logic [N-1:0]        req_valid;
   logic [N-1:0][W-1:0] req_data;
   logic [N-1:0]        req_last;
   logic [N-1:0]        req_ready;
   logic                full;
   logic                push;
   logic [W-1:0]        data_in;
   logic [1:0]          grant_id;
   logic                busy;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] data;
   } sb_t;

   sb_t    sb_q[$];
   int     push_log[$];
   data_ty words[N][16];
   logic   lasts[N][16];
   int     head[N];
   int     tail[N];
   logic [N-1:0] mute;
   logic [N-1:0] acc;
   int     n_cmp = 0;
   int     n_bad = 0;
   int     cyc = 0;
   int     base = 0;

   always #5 clk_wr = ~clk_wr;

   always @(posedge clk_wr) cyc <= cyc + 1;

   always_comb begin
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      for (int i = 0; i < N; i++) begin
         req_valid[i] = (head[i] != tail[i]) && !mute[i];
         req_data[i]  = words[i][head[i] % 16];
         req_last[i]  = lasts[i][head[i] % 16];
      end
   end

   afifo_wr_arbiter #(.N_REQ(N), .BURST_MAX(BM), .WIDTH(W)) dut (
      .clk_wr    (clk_wr),
      .wr_rst    (wr_rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .full      (full),
      .push      (push),
      .data_in   (data_in),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   afifo_wr_arbiter_chk #(.N_REQ(N)) u_chk (
      .clk_wr    (clk_wr),
      .wr_rst    (wr_rst),
      .req_ready (req_ready),
      .push      (push),
      .full      (full),
      .grant_id  (grant_id)
   );

   // Monitor: score every push mid-cycle, then advance accepted requester queues
   always begin
      sb_t e;
      @(negedge clk_wr);
      acc = req_valid & req_ready;
      if (push === 1'b1) begin
         push_log.push_back(cyc);
         n_cmp++;
         if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL sb_unexpected: push id=%0d data=%h, none expected", grant_id, data_in);
         end else begin
            e = sb_q.pop_front();
            if (grant_id !== e.id || data_in !== e.data) begin
               n_bad++;
               $display("FAIL sb_word: got id=%0d data=%h, expected id=%0d data=%h",
                        grant_id, data_in, e.id, e.data);
            end
         end
      end
      @(posedge clk_wr);
      #1;
      for (int i = 0; i < N; i++) if (acc[i]) head[i]++;
   end

   task automatic load(input int id, input logic [7:0] d, input logic l, input bit exp);
      words[id][tail[id]] = d;
      lasts[id][tail[id]] = l;
      tail[id]++;
      if (exp) sb_q.push_back('{id: 2'(id), data: d});
   endtask

   task automatic apply_reset();
      wr_rst = 1'b0;
      full   = 1'b0;
      mute   = '0;
      for (int i = 0; i < N; i++) begin
         head[i] = 0;
         tail[i] = 0;
      end
      sb_q.delete();
      push_log.delete();
      repeat (2) @(posedge clk_wr);
      #2;
      wr_rst = 1'b1;
      base   = cyc;
   endtask

   task automatic test_reset();
      wr_rst = 1'b0;
      full   = 1'b0;
      load(1, 8'h5A, 1'b1, 1'b0);
      @(negedge clk_wr);
      n_cmp++; if (push !== 1'b0) begin n_bad++; $display("FAIL rst_push: got %b, expected 0", push); end
      n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_ready: got %b, expected 0000", req_ready); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b, expected 0", busy); end
      n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL rst_grant: got %0d, expected 0", grant_id); end
      n_cmp++; if (data_in !== 8'h00) begin n_bad++; $display("FAIL rst_data: got %h, expected 00", data_in); end
      apply_reset();
      for (int c = 1; c <= 3; c++) begin
         @(posedge clk_wr); #2;
         @(negedge clk_wr);
         n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_no_req: cycle %0d busy=%b, expected 0", c, busy); end
      end
      n_cmp++; if (push_log.size() != 0) begin n_bad++; $display("FAIL idle_push_count: got %0d, expected 0", push_log.size()); end
   endtask

   task automatic test_single();
      int exp_c[$] = '{1, 2, 3, 5, 7};
      apply_reset();
      load(2, 8'hA1, 1'b0, 1'b1);
      load(2, 8'hA2, 1'b0, 1'b1);
      load(2, 8'hA3, 1'b1, 1'b1);
      for (int c = 1; c <= 9; c++) begin
         @(posedge clk_wr); #2;
         @(negedge clk_wr);
         if (c == 1) begin
            n_cmp++; if (grant_id !== 2'd2) begin n_bad++; $display("FAIL single_grant: got %0d, expected 2", grant_id); end
            n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b, expected 1", busy); end
         end
         if (c == 4) begin
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_idle: got busy=%b, expected 0", busy); end
            load(3, 8'hB3, 1'b1, 1'b1);
            load(0, 8'hB0, 1'b1, 1'b1);
         end
         if (c == 5) begin
            n_cmp++; if (grant_id !== 2'd3) begin n_bad++; $display("FAIL single_rr_ptr: got grant %0d, expected 3", grant_id); end
         end
      end
      n_cmp++; if (push_log.size() != exp_c.size()) begin n_bad++; $display("FAIL single_push_count: got %0d, expected %0d", push_log.size(), exp_c.size()); end
      for (int k = 0; k < exp_c.size(); k++) begin
         int got;
         got = (k < push_log.size()) ? push_log[k] - base : -1;
         n_cmp++; if (got != exp_c[k]) begin n_bad++; $display("FAIL single_push_cycle: push %0d at cycle %0d, expected %0d", k, got, exp_c[k]); end
      end
      n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL single_drain: %0d words left, expected 0", sb_q.size()); end
   endtask

   task automatic test_round_robin();
      int exp_c[$] = '{1, 3, 5, 7, 9};
      apply_reset();
      load(0, 8'h10, 1'b1, 1'b1);
      load(1, 8'h11, 1'b1, 1'b1);
      load(2, 8'h12, 1'b1, 1'b1);
      load(3, 8'h13, 1'b1, 1'b1);
      load(0, 8'h14, 1'b1, 1'b1);
      for (int c = 1; c <= 11; c++) begin
         @(posedge clk_wr); #2;
         @(negedge clk_wr);
         if (c == 2 || c == 4 || c == 6 || c == 8) begin
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rr_bubble: cycle %0d busy=%b, expected 0", c, busy); end
         end
         if (c == 9) begin
            n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL rr_wrap: got grant %0d, expected 0", grant_id); end
         end
      end
      n_cmp++; if (push_log.size() != exp_c.size()) begin n_bad++; $display("FAIL rr_push_count: got %0d, expected %0d", push_log.size(), exp_c.size()); end
      for (int k = 0; k < exp_c.size(); k++) begin
         int got;
         got = (k < push_log.size()) ? push_log[k] - base : -1;
         n_cmp++; if (got != exp_c[k]) begin n_bad++; $display("FAIL rr_push_cycle: push %0d at cycle %0d, expected %0d", k, got, exp_c[k]); end
      end
      n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL rr_drain: %0d words left, expected 0", sb_q.size()); end
   endtask

   task automatic test_burst_cap();
      int exp_c[$] = '{1, 2, 3, 4, 6, 7, 8, 9, 11, 12};
      apply_reset();
      for (int k = 0; k < 10; k++) load(1, 8'(32'h20 + k), 1'b0, 1'b1);
      for (int c = 1; c <= 15; c++) begin
         @(posedge clk_wr); #2;
         @(negedge clk_wr);
         if (c == 5 || c == 10 || c == 14) begin
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL cap_bubble: cycle %0d busy=%b, expected 0", c, busy); end
         end
         if (c == 6 || c == 11) begin
            n_cmp++; if (grant_id !== 2'd1) begin n_bad++; $display("FAIL cap_grant: cycle %0d grant %0d, expected 1", c, grant_id); end
         end
      end
      n_cmp++; if (push_log.size() != exp_c.size()) begin n_bad++; $display("FAIL cap_push_count: got %0d, expected %0d", push_log.size(), exp_c.size()); end
      for (int k = 0; k < exp_c.size(); k++) begin
         int got;
         got = (k < push_log.size()) ? push_log[k] - base : -1;
         n_cmp++; if (got != exp_c[k]) begin n_bad++; $display("FAIL cap_push_cycle: push %0d at cycle %0d, expected %0d", k, got, exp_c[k]); end
      end
      n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL cap_drain: %0d words left, expected 0", sb_q.size()); end
   endtask

   task automatic test_full_stall();
      int exp_c[$] = '{1, 2, 8, 9};
      apply_reset();
      load(0, 8'h30, 1'b0, 1'b1);
      load(0, 8'h31, 1'b0, 1'b1);
      load(0, 8'h32, 1'b0, 1'b1);
      load(0, 8'h33, 1'b1, 1'b1);
      for (int c = 1; c <= 11; c++) begin
         @(posedge clk_wr); #2;
         full = (c >= 3 && c <= 7);
         @(negedge clk_wr);
         if (c >= 3 && c <= 7) begin
            n_cmp++; if (push !== 1'b0) begin n_bad++; $display("FAIL stall_push: cycle %0d push=%b, expected 0", c, push); end
            n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL stall_ready: cycle %0d ready=%b, expected 0000", c, req_ready); end
            n_cmp++; if (dut.beat_cnt_r !== 3'd2) begin n_bad++; $display("FAIL stall_beat: cycle %0d beat=%0d, expected 2", c, dut.beat_cnt_r); end
            n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL stall_busy: cycle %0d busy=%b, expected 1", c, busy); end
         end
      end
      full = 1'b0;
      n_cmp++; if (push_log.size() != exp_c.size()) begin n_bad++; $display("FAIL stall_push_count: got %0d, expected %0d", push_log.size(), exp_c.size()); end
      for (int k = 0; k < exp_c.size(); k++) begin
         int got;
         got = (k < push_log.size()) ? push_log[k] - base : -1;
         n_cmp++; if (got != exp_c[k]) begin n_bad++; $display("FAIL stall_push_cycle: push %0d at cycle %0d, expected %0d", k, got, exp_c[k]); end
      end
      n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL stall_drain: %0d words left, expected 0", sb_q.size()); end
   endtask

   task automatic test_abandon();
      int exp_c[$] = '{1, 4, 6};
      apply_reset();
      load(0, 8'h40, 1'b0, 1'b1);
      load(3, 8'h43, 1'b1, 1'b1);
      load(0, 8'h41, 1'b0, 1'b1);
      for (int c = 1; c <= 9; c++) begin
         @(posedge clk_wr); #2;
         mute[0] = (c == 2);
         @(negedge clk_wr);
         if (c == 2) begin
            n_cmp++; if (push !== 1'b0) begin n_bad++; $display("FAIL abandon_push: got %b, expected 0", push); end
         end
         if (c == 3) begin
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abandon_release: busy=%b, expected 0", busy); end
         end
         if (c == 4) begin
            n_cmp++; if (grant_id !== 2'd3) begin n_bad++; $display("FAIL abandon_next: grant %0d, expected 3", grant_id); end
         end
         if (c == 6) begin
            n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL abandon_return: grant %0d, expected 0", grant_id); end
         end
      end
      n_cmp++; if (push_log.size() != exp_c.size()) begin n_bad++; $display("FAIL abandon_push_count: got %0d, expected %0d", push_log.size(), exp_c.size()); end
      for (int k = 0; k < exp_c.size(); k++) begin
         int got;
         got = (k < push_log.size()) ? push_log[k] - base : -1;
         n_cmp++; if (got != exp_c[k]) begin n_bad++; $display("FAIL abandon_push_cycle: push %0d at cycle %0d, expected %0d", k, got, exp_c[k]); end
      end
      n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL abandon_drain: %0d words left, expected 0", sb_q.size()); end
   endtask

   task automatic test_async_reset();
      int exp_c[$] = '{1, 3};
      apply_reset();
      load(2, 8'h50, 1'b1, 1'b1);
      for (int c = 1; c <= 3; c++) begin
         @(posedge clk_wr); #2;
         if (c == 2) begin
            load(1, 8'h60, 1'b0, 1'b1);
            load(1, 8'h61, 1'b0, 1'b0);
            load(1, 8'h62, 1'b0, 1'b0);
            load(1, 8'h63, 1'b1, 1'b0);
         end
         @(negedge clk_wr);
      end
      @(posedge clk_wr); #2;
      wr_rst = 1'b0;
      #1;
      n_cmp++; if (push !== 1'b0) begin n_bad++; $display("FAIL arst_push: got %b, expected 0", push); end
      n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL arst_ready: got %b, expected 0000", req_ready); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL arst_busy: got %b, expected 0", busy); end
      n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL arst_grant: got %0d, expected 0", grant_id); end
      n_cmp++; if (push_log.size() != exp_c.size()) begin n_bad++; $display("FAIL arst_push_count: got %0d, expected %0d", push_log.size(), exp_c.size()); end
      for (int k = 0; k < exp_c.size(); k++) begin
         int got;
         got = (k < push_log.size()) ? push_log[k] - base : -1;
         n_cmp++; if (got != exp_c[k]) begin n_bad++; $display("FAIL arst_push_cycle: push %0d at cycle %0d, expected %0d", k, got, exp_c[k]); end
      end
      n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL arst_drain: %0d words left, expected 0", sb_q.size()); end
      apply_reset();
      load(0, 8'h70, 1'b1, 1'b1);
      load(3, 8'h73, 1'b1, 1'b1);
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk_wr); #2;
         @(negedge clk_wr);
         if (c == 1) begin
            n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL arst_restart: grant %0d, expected 0", grant_id); end
            n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL arst_restart_busy: busy=%b, expected 1", busy); end
         end
      end
      n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL arst_restart_drain: %0d words left, expected 0", sb_q.size()); end
   endtask

   initial begin
      wr_rst = 1'b0;
      full   = 1'b0;
      mute   = '0;
      acc    = '0;
      for (int i = 0; i < N; i++) begin
         head[i] = 0;
         tail[i] = 0;
      end
      test_reset();
      test_single();
      test_round_robin();
      test_burst_cap();
      test_full_stall();
      test_abandon();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
